seq_div16_ctrl: RTL and testbench
=================================

Name: seq_div16_ctrl

Overview:
Multi-cycle unsigned restoring divider controller for the CPU's DIV/MOD path. It owns one N-bit ripple subtractor and reuses it once per cycle, producing one quotient bit per iteration. It sits beside the ALU: the instruction sequencer pulses start and waits for done, so no extra arithmetic hardware is needed.

Parameters:
N, 16, operand/result width; also sets the iteration count.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request a division; sampled only in IDLE or DONE.
dividend  input  N  unsigned dividend; captured on accepted start.
divisor  input  N  unsigned divisor; captured on accepted start.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid.
quotient  output  N  registered quotient.
remainder  output  N  registered remainder.
div_by_zero  output  1  registered; set when the last accepted divisor was 0.

Behaviour:
- Reset (synchronous, any state, including mid-CALC): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal registers=0. The in-flight operation is discarded.
- States: IDLE, CALC, DONE.
- IDLE/DONE with start=1 and divisor!=0: load Q=dividend, R=0, D=divisor, cnt=0, and go to CALC. DONE is a legal accept point, so back-to-back operations lose no cycle.
- IDLE/DONE with start=1 and divisor==0: go directly to DONE on that edge. quotient={N{1}}, remainder=dividend, div_by_zero=1.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- CALC iteration (one per edge):
  - S = {R, Q[N-1]} (N+1 bits).
  - The subtractor computes S[N-1:0] - D with borrow-in 0.
  - ok = S[N] | ~borrow_out.
  - If ok: R = difference. Else: R = S[N-1:0].
  - Q = {Q[N-2:0], ok}; cnt++.
  - The borrow_out of an N-bit subtract is ignored when S[N]=1, because S >= 2^N > D.
- After the Nth CALC edge (cnt==N-1): go to DONE. quotient=Q, remainder=R, div_by_zero=0.
- Latency: if start is sampled on edge k, CALC edges are k+1..k+N. done=1 for the single cycle after edge k+N. busy=1 after edge k through edge k+N.
- Divide-by-zero latency: done=1 in the cycle after edge k.
- start while busy is ignored; operand changes during CALC have no effect.
- quotient, remainder and div_by_zero update only on entering DONE and hold until the next entry into DONE or reset.
- done is never high for two consecutive cycles unless a new start is accepted in DONE. In that case the next done comes N+1 cycles later.
- Invariants: done and busy are never both 1. R < D throughout CALC.

Decomposition:
- Package div_pkg:
  - DIV_W=16.
  - Enum state_t {IDLE, CALC, DONE}.
  - Localparam CNT_W = $clog2(DIV_W).
- Sub-module: instantiate the existing N-bit ripple subtractor a16bitsub (N=16, bin=0) once for the datapath.
- All control logic is a single always_ff FSM plus counter; no further hierarchy.

Test Plan:
- 100 / 7 -> 16 cycles after the start edge: done pulse, quotient=14, remainder=2, div_by_zero=0. busy high for exactly 16 cycles.
- 0xFFFF / 0x8001 (S[N] overflow path) -> quotient=1, remainder=0x7FFE. Also 0xFFFF / 1 -> quotient=0xFFFF, remainder=0.
- 0x8000 / 0xFFFF -> quotient=0, remainder=0x8000. Also 0 / 5 -> quotient=0, remainder=0.
- 1234 / 0 -> done in the next cycle, quotient=0xFFFF, remainder=1234, div_by_zero=1, busy never asserted.
- Start re-pulsed with new operands during CALC -> ignored, first result correct. Then start held high in the DONE cycle with 50/6 -> accepted, next done 16 cycles later with quotient=8, remainder=2.
- rst asserted at CALC iteration 5 -> next cycle IDLE with all outputs 0. A fresh start 9/3 then returns quotient=3, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider controller.
package div_pkg;

    localparam int DIV_W = 16;
    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_div16_ctrl_if.sv
// Start/done handshake and operand/result bus between the sequencer and the divider.
interface seq_div16_ctrl_if
    import div_pkg::*;
#(
    parameter int N = DIV_W
);

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/a16bitsub.sv
// N-bit ripple-borrow subtractor: diff = a - b - bin, bout set when the result wraps.
module a16bitsub #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] diff,
    output logic         bout
);

    always_comb begin
        logic borrow;
        diff   = '0;
        borrow = bin;
        for (int i = 0; i < N; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
        end
        bout = borrow;
    end

endmodule

// File: rtl/seq_div16_ctrl.sv
// Restoring unsigned divider: one shared subtractor, one quotient bit per CALC cycle.
module seq_div16_ctrl
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_div16_ctrl_if.slave      bus
);

    localparam int CW = $clog2(N);

    state_t        state, state_n;
    logic [N-1:0]  q_reg, q_n;
    logic [N-1:0]  r_reg, r_n;
    logic [N-1:0]  d_reg, d_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  quo_reg, quo_n;
    logic [N-1:0]  rem_reg, rem_n;
    logic          dbz_reg, dbz_n;

    logic [N:0]    s;
    logic [N-1:0]  diff;
    logic          bout;
    logic          ok;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign s = {r_reg, q_reg[N-1]};

    a16bitsub #(.N(N)) u_sub (
        .a    (s[N-1:0]),
        .b    (d_reg),
        .bin  (1'b0),
        .diff (diff),
        .bout (bout)
    );

    // A set S[N] means S >= 2^N > D, so the subtract fits even though it borrowed.
    assign ok = s[N] | ~bout;

    always_comb begin
        state_n = state;
        q_n     = q_reg;
        r_n     = r_reg;
        d_n     = d_reg;
        cnt_n   = cnt;
        quo_n   = quo_reg;
        rem_n   = rem_reg;
        dbz_n   = dbz_reg;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        q_n     = bus.dividend;
                        r_n     = '0;
                        d_n     = bus.divisor;
                        cnt_n   = '0;
                        state_n = CALC;
                    end else begin
                        quo_n   = '1;
                        rem_n   = bus.dividend;
                        dbz_n   = 1'b1;
                        state_n = DONE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                r_n   = ok ? diff : s[N-1:0];
                q_n   = {q_reg[N-2:0], ok};
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    quo_n   = {q_reg[N-2:0], ok};
                    rem_n   = ok ? diff : s[N-1:0];
                    dbz_n   = 1'b0;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
            cnt     <= '0;
            quo_reg <= '0;
            rem_reg <= '0;
            dbz_reg <= 1'b0;
        end else begin
            state   <= state_n;
            q_reg   <= q_n;
            r_reg   <= r_n;
            d_reg   <= d_n;
            cnt     <= cnt_n;
            quo_reg <= quo_n;
            rem_reg <= rem_n;
            dbz_reg <= dbz_n;
        end
    end

    assign bus.busy        = (state == CALC);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div16_ctrl.sv
// Bench for seq_div16_ctrl: fixed vectors, randomized operands against a/b, multi-cycle corners.
module tb_seq_div16_ctrl;

    logic clk;
    logic rst;

    seq_div16_ctrl_if #(.N(16)) bus ();

    seq_div16_ctrl #(.N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start    = 1'b0;
    endtask

    // Cycles counted from the start edge until done is seen, bounded.
    task automatic wait_done(output int cyc, output int busy_cnt, output int overlap);
        cyc = 0;
        busy_cnt = 0;
        overlap = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            cyc++;
        end
        if (bus.done && bus.busy) overlap++;
    endtask

    task automatic run_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] eq, input logic [15:0] er, input logic edbz);
        int cyc, bc, ov;
        start_op(a, b);
        wait_done(cyc, bc, ov);
        check({name, ".latency"}, cyc, edbz ? 0 : 16);
        check({name, ".busy_cycles"}, bc, edbz ? 0 : 16);
        check({name, ".done_busy_overlap"}, ov, 0);
        check({name, ".quotient"}, bus.quotient, eq);
        check({name, ".remainder"}, bus.remainder, er);
        check({name, ".div_by_zero"}, bus.div_by_zero, edbz);
        tick();
        check({name, ".done_pulse_end"}, bus.done, 0);
        check({name, ".quotient_hold"}, bus.quotient, eq);
    endtask

    initial begin
        int cyc, bc, ov;
        logic [15:0] a, b, eq, er;
        logic edbz;

        tbl[0] = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0};
        tbl[1] = '{16'hFFFF,  16'h8001,   16'd1,      16'h7FFE,   1'b0};
        tbl[2] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0};
        tbl[3] = '{16'h8000,  16'hFFFF,   16'd0,      16'h8000,   1'b0};
        tbl[4] = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0};
        tbl[5] = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234,   1'b1};
        tbl[6] = '{16'd50,    16'd6,      16'd8,      16'd2,      1'b0};
        tbl[7] = '{16'd9,     16'd3,      16'd3,      16'd0,      1'b0};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        tick();
        tick();
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check("reset.quotient", bus.quotient, 0);
        check("reset.remainder", bus.remainder, 0);
        check("reset.div_by_zero", bus.div_by_zero, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);
        end

        // Randomized operands, reference is plain integer division.
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            edbz = (b == 0);
            eq = edbz ? 16'hFFFF : a / b;
            er = edbz ? a : a % b;
            run_and_check($sformatf("rnd%0d", i), a, b, eq, er, edbz);
        end

        // Start re-pulsed with new operands mid-CALC is ignored.
        start_op(16'd200, 16'd9);
        tick();
        tick();
        tick();
        bus.start = 1'b1;
        bus.dividend = 16'd77;
        bus.divisor = 16'd0;
        tick();
        bus.start = 1'b0;
        check("repulse.busy", bus.busy, 1);
        wait_done(cyc, bc, ov);
        check("repulse.latency", cyc + 4, 16);
        check("repulse.quotient", bus.quotient, 22);
        check("repulse.remainder", bus.remainder, 2);
        check("repulse.div_by_zero", bus.div_by_zero, 0);

        // Back-to-back: new start accepted in the DONE cycle.
        start_op(16'd50, 16'd6);
        check("b2b.accept_busy", bus.busy, 1);
        check("b2b.accept_done", bus.done, 0);
        wait_done(cyc, bc, ov);
        check("b2b.latency", cyc, 16);
        check("b2b.quotient", bus.quotient, 8);
        check("b2b.remainder", bus.remainder, 2);
        tick();

        // Reset on CALC iteration 5 discards the operation and clears outputs.
        start_op(16'd1000, 16'd7);
        for (int i = 0; i < 4; i++) tick();
        check("midrst.busy_before", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", bus.busy, 0);
        check("midrst.done", bus.done, 0);
        check("midrst.quotient", bus.quotient, 0);
        check("midrst.remainder", bus.remainder, 0);
        check("midrst.div_by_zero", bus.div_by_zero, 0);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done || bus.busy) cyc++;
        end
        check("midrst.stays_idle", cyc, 0);
        run_and_check("after_rst", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
